// File: rtl/pong_pkg.sv
// pong_pkg: shared match-state encoding, serve directions and score width.
package pong_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        RALLY = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } match_state_t;
    localparam logic SERVE_TOP = 1'b0;
    localparam logic SERVE_BOT = 1'b1;
    localparam int   SCORE_W   = 4;
endpackage

// File: rtl/sync_rise_det.sv
// sync_rise_det: optional 2-flop synchroniser followed by a rising-edge detector.
//   i_clk, i_reset (sync, active-low), i_d (raw or synchronous level), o_rise (1-cycle pulse).
//   All history resets to 1 so a level held high through reset never reads as a rise.
module sync_rise_det #(
    parameter bit BYPASS = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_rise
);
    logic w_d;
    logic r_hist;
    generate
        if (BYPASS) begin : g_byp
            assign w_d = i_d;
        end else begin : g_sync
            logic [1:0] r_sync;
            always_ff @(posedge i_clk) begin
                if (!i_reset) r_sync <= 2'b11;
                else          r_sync <= {r_sync[0], i_d};
            end
            assign w_d = r_sync[1];
        end
    endgenerate
    always_ff @(posedge i_clk) begin
        if (!i_reset) r_hist <= 1'b1;
        else          r_hist <= w_d;
    end
    assign o_rise = w_d & ~r_hist;
endmodule

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: match sequencer deciding ball hold/launch, scoring, serve timing and win.
//   Inputs : i_clk, i_reset (sync, active-low), i_start, i_start_ball (raw buttons),
//            i_frame_tick, i_score_top, i_score_bot (synchronous).
//   Outputs: o_ball_enable, o_ball_hold, o_serve_dir, o_p1_score, o_p2_score,
//            o_game_over, o_winner, o_state -- all registered.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE            = 9,
    parameter int POINT_DELAY_FRAMES   = 60,
    parameter int SERVE_TIMEOUT_FRAMES = 300
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_start_ball,
    input  logic               i_frame_tick,
    input  logic               i_score_top,
    input  logic               i_score_bot,
    output logic               o_ball_enable,
    output logic               o_ball_hold,
    output logic               o_serve_dir,
    output logic [SCORE_W-1:0] o_p1_score,
    output logic [SCORE_W-1:0] o_p2_score,
    output logic               o_game_over,
    output logic               o_winner,
    output logic [2:0]         o_state
);
    localparam int CNT_MAX = POINT_DELAY_FRAMES > SERVE_TIMEOUT_FRAMES ? POINT_DELAY_FRAMES : SERVE_TIMEOUT_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 2);
    localparam logic [CNT_W-1:0]   PD_C       = CNT_W'(POINT_DELAY_FRAMES);
    localparam logic [CNT_W-1:0]   TO_C       = CNT_W'(SERVE_TIMEOUT_FRAMES);
    localparam logic [SCORE_W-1:0] WIN_C      = SCORE_W'(WIN_SCORE);
    localparam bit                 AUTO_SERVE = SERVE_TIMEOUT_FRAMES != 0;

    logic w_start, w_serve, w_top, w_bot;
    sync_rise_det #(.BYPASS(1'b0)) u_start (.i_clk(i_clk), .i_reset(i_reset), .i_d(i_start),      .o_rise(w_start));
    sync_rise_det #(.BYPASS(1'b0)) u_serve (.i_clk(i_clk), .i_reset(i_reset), .i_d(i_start_ball), .o_rise(w_serve));
    sync_rise_det #(.BYPASS(1'b1)) u_top   (.i_clk(i_clk), .i_reset(i_reset), .i_d(i_score_top),  .o_rise(w_top));
    sync_rise_det #(.BYPASS(1'b1)) u_bot   (.i_clk(i_clk), .i_reset(i_reset), .i_d(i_score_bot),  .o_rise(w_bot));

    match_state_t       r_state, w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [SCORE_W-1:0] r_p1, r_p2, w_p1, w_p2;
    logic               r_dir, w_dir, r_win, w_win;
    logic               r_en, r_hold, r_over, w_en, w_hold, w_over;
    logic               w_entry;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_p1    <= '0;
            r_p2    <= '0;
            r_dir   <= 1'b0;
            r_win   <= 1'b0;
            r_en    <= 1'b0;
            r_hold  <= 1'b0;
            r_over  <= 1'b0;
        end else begin
            r_state <= w_next;
            // entry clear beats a coincident frame tick; the counter sticks at all-ones
            r_cnt   <= w_entry ? '0 : (i_frame_tick && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
            r_p1    <= w_p1;
            r_p2    <= w_p2;
            r_dir   <= w_dir;
            r_win   <= w_win;
            r_en    <= w_en;
            r_hold  <= w_hold;
            r_over  <= w_over;
        end
    end

    always_comb begin
        w_next = r_state;
        w_p1   = r_p1;
        w_p2   = r_p2;
        w_dir  = r_dir;
        w_win  = r_win;
        if (w_start) begin
            w_next = SERVE;
            w_p1   = '0;
            w_p2   = '0;
            w_win  = 1'b0;
            if (r_state != OVER) w_dir = SERVE_BOT;
        end else begin
            case (r_state)
                SERVE: if (w_serve || (AUTO_SERVE && r_cnt == TO_C)) w_next = RALLY;
                RALLY: if (w_top || w_bot) begin
                    w_next = POINT;
                    // simultaneous rises are a let: no score, direction kept
                    if (w_top && !w_bot) begin
                        w_p1  = r_p1 == WIN_C ? r_p1 : r_p1 + 1'b1;
                        w_dir = SERVE_BOT;
                    end else if (w_bot && !w_top) begin
                        w_p2  = r_p2 == WIN_C ? r_p2 : r_p2 + 1'b1;
                        w_dir = SERVE_TOP;
                    end
                end
                POINT: if (r_cnt == PD_C) begin
                    if (r_p1 == WIN_C || r_p2 == WIN_C) begin
                        w_next = OVER;
                        w_win  = r_p1 != WIN_C;
                    end else begin
                        w_next = SERVE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_entry = w_start || (w_next != r_state);
        w_en    = w_next == RALLY;
        w_hold  = w_next != RALLY;
        w_over  = w_next == OVER;
    end

    assign o_ball_enable = r_en;
    assign o_ball_hold   = r_hold;
    assign o_serve_dir   = r_dir;
    assign o_p1_score    = r_p1;
    assign o_p2_score    = r_p2;
    assign o_game_over   = r_over;
    assign o_winner      = r_win;
    assign o_state       = r_state;
endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb_pong_match_ctrl: directed stimulus, event-level match model checked every cycle, plus literal pins.
module tb_pong_match_ctrl;
    localparam int WIN = 3;
    localparam int PD  = 2;
    localparam int TO  = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0, start_ball = 1'b0, frame_tick = 1'b0, score_top = 1'b0, score_bot = 1'b0;
    logic ball_enable, ball_hold, serve_dir, game_over, winner;
    logic [3:0] p1_score, p2_score;
    logic [2:0] state_o;

    int total = 0;
    int bad   = 0;
    bit chk   = 1'b0;

    always #5 clk = ~clk;

    pong_match_ctrl #(
        .WIN_SCORE(WIN), .POINT_DELAY_FRAMES(PD), .SERVE_TIMEOUT_FRAMES(TO)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_start_ball(start_ball),
        .i_frame_tick(frame_tick), .i_score_top(score_top), .i_score_bot(score_bot),
        .o_ball_enable(ball_enable), .o_ball_hold(ball_hold), .o_serve_dir(serve_dir),
        .o_p1_score(p1_score), .o_p2_score(p2_score), .o_game_over(game_over),
        .o_winner(winner), .o_state(state_o)
    );

    // model: state numbers follow the published enum order IDLE..OVER = 0..4
    int   m_st, m_p1, m_p2, m_frames, nst;
    logic m_dir, m_win, m_en, m_hold, m_over;
    logic [2:0] s_hist, b_hist;
    logic t_prev, b_prev, s_press, b_press, t_rise, b_rise;

    always @(posedge clk) begin
        if (!reset) begin
            m_st = 0; m_p1 = 0; m_p2 = 0; m_frames = 0;
            m_dir = 0; m_win = 0; m_en = 0; m_hold = 0; m_over = 0;
            s_hist = 3'b111; b_hist = 3'b111; t_prev = 1; b_prev = 1;
        end else begin
            // a button counts when the sample two edges ago is high and the one before it low
            s_press = s_hist[1] & ~s_hist[2];
            b_press = b_hist[1] & ~b_hist[2];
            t_rise  = score_top & ~t_prev;
            b_rise  = score_bot & ~b_prev;
            s_hist  = {s_hist[1:0], start};
            b_hist  = {b_hist[1:0], start_ball};
            t_prev  = score_top;
            b_prev  = score_bot;
            nst = m_st;
            if (s_press) begin
                if (m_st != 4) m_dir = 1;
                nst = 1; m_p1 = 0; m_p2 = 0; m_win = 0;
            end else if (m_st == 1 && (b_press || m_frames == TO)) begin
                nst = 2;
            end else if (m_st == 2 && (t_rise || b_rise)) begin
                nst = 3;
                if (t_rise && !b_rise) begin m_p1 = m_p1 + 1; m_dir = 1; end
                if (b_rise && !t_rise) begin m_p2 = m_p2 + 1; m_dir = 0; end
            end else if (m_st == 3 && m_frames == PD) begin
                if (m_p1 == WIN)      begin nst = 4; m_win = 0; end
                else if (m_p2 == WIN) begin nst = 4; m_win = 1; end
                else                  nst = 1;
            end
            m_frames = (s_press || nst != m_st) ? 0 : m_frames + int'(frame_tick);
            m_st   = nst;
            m_en   = m_st == 2;
            m_hold = m_st != 2;
            m_over = m_st == 4;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk) begin
            check("ball_enable", int'(ball_enable), int'(m_en));
            check("ball_hold",   int'(ball_hold),   int'(m_hold));
            check("serve_dir",   int'(serve_dir),   int'(m_dir));
            check("p1_score",    int'(p1_score),    m_p1);
            check("p2_score",    int'(p2_score),    m_p2);
            check("game_over",   int'(game_over),   int'(m_over));
            check("winner",      int'(winner),      int'(m_win));
            check("state",       int'(state_o),     m_st);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic press_start;
        start = 1; cyc(2); start = 0; cyc(4);
    endtask
    task automatic press_ball;
        start_ball = 1; cyc(2); start_ball = 0; cyc(4);
    endtask
    task automatic tick;
        frame_tick = 1; cyc(1); frame_tick = 0; cyc(2);
    endtask
    task automatic strobe(input logic t, input logic b);
        score_top = t; score_bot = b; cyc(2); score_top = 0; score_bot = 0; cyc(2);
    endtask

    initial begin
        start = 1;
        cyc(1);
        chk = 1;
        cyc(2);
        check("lit_reset_state", int'(state_o), 0);
        check("lit_reset_hold", int'(ball_hold), 0);
        reset = 1;
        cyc(6);
        check("lit_held_start_idle", int'(state_o), 0);
        check("lit_held_start_p1", int'(p1_score), 0);
        check("lit_idle_hold", int'(ball_hold), 1);
        start = 0;
        cyc(4);
        press_start;
        check("lit_serve", int'(state_o), 1);
        check("lit_serve_dir", int'(serve_dir), 1);
        press_ball;
        check("lit_rally", int'(state_o), 2);
        check("lit_rally_en", int'(ball_enable), 1);
        for (int i = 0; i < 3; i++) begin
            strobe(1, 0);
            check("lit_point_state", int'(state_o), 3);
            check("lit_point_p1", int'(p1_score), i + 1);
            tick;
            tick;
            if (i < 2) begin
                check("lit_back_to_serve", int'(state_o), 1);
                press_ball;
            end
        end
        check("lit_over_state", int'(state_o), 4);
        check("lit_over_flag", int'(game_over), 1);
        check("lit_winner", int'(winner), 0);
        check("lit_over_dir", int'(serve_dir), 1);
        press_start;
        check("lit_restart_state", int'(state_o), 1);
        check("lit_restart_p1", int'(p1_score), 0);
        press_ball;
        strobe(1, 1);
        check("lit_let_state", int'(state_o), 3);
        check("lit_let_p1", int'(p1_score), 0);
        check("lit_let_p2", int'(p2_score), 0);
        tick;
        // second tick held for two cycles: the latter lands on the SERVE entry edge
        frame_tick = 1; cyc(2); frame_tick = 0; cyc(2);
        check("lit_let_serve", int'(state_o), 1);
        tick; tick; tick;
        check("lit_timeout_not_yet", int'(state_o), 1);
        tick;
        check("lit_timeout_rally", int'(state_o), 2);
        for (int i = 0; i < 2; i++) begin
            strobe(0, 1);
            tick;
            tick;
            press_ball;
        end
        check("lit_p2_two", int'(p2_score), 2);
        check("lit_p2_dir", int'(serve_dir), 0);
        press_start;
        check("lit_abort_state", int'(state_o), 1);
        check("lit_abort_p2", int'(p2_score), 0);
        check("lit_abort_dir", int'(serve_dir), 1);
        strobe(1, 0);
        check("lit_serve_ignore_state", int'(state_o), 1);
        check("lit_serve_ignore_p1", int'(p1_score), 0);
        reset = 0;
        cyc(2);
        check("lit_midreset_state", int'(state_o), 0);
        check("lit_midreset_dir", int'(serve_dir), 0);
        chk = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
